// File: rtl/fp_special_result_pack_if.sv
// ---------------------------------------------------------------------------
// fp_special_result_pack_if
//   Bundles the input beat (raw FMA result plus special-case overrides) and the
//   output beat (final IEEE-754 word plus exception flags) of
//   fp_special_result_pack.
//
//   Handshake: a beat moves on a side exactly on a rising clock edge where
//   valid and ready are both high. The producer holds valid and its payload
//   steady until that edge. The consumer may change ready at any time.
//
//   Modports:
//     master : upstream/downstream environment (drives inputs, sees outputs)
//     slave  : fp_special_result_pack itself
//
//   Parameter:
//     WIDTH : FP word width
// ---------------------------------------------------------------------------
interface fp_special_result_pack_if #(
  parameter int WIDTH = 32
);
  // input side
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] rawResult;
  logic             setResultNaN;
  logic             setResultPInf;
  logic             setResultNInf;
  // output side
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] result;
  logic             flagInvalid;
  logic             flagOverflow;

  modport master (
    output inValid, rawResult, setResultNaN, setResultPInf, setResultNInf,
    output outReady,
    input  inReady, outValid, result, flagInvalid, flagOverflow
  );

  modport slave (
    input  inValid, rawResult, setResultNaN, setResultPInf, setResultNInf,
    input  outReady,
    output inReady, outValid, result, flagInvalid, flagOverflow
  );
endinterface

// File: rtl/fp_special_result_pack.sv
// ---------------------------------------------------------------------------
// fp_special_result_pack
//   Final result packing at the FMA output, after rounding. It resolves
//   operand special cases (NaN, +Inf, -Inf, Inf-Inf) and exponent overflow
//   into the IEEE-754 result word. It raises invalid/overflow flags and hands
//   each beat on through a 2-entry output buffer.
//
//   Ports:
//     clk            : clock, rising edge
//     rst            : synchronous active-high reset
//     bus (slave)    : in/out handshake, raw result, override flags, result,
//                      and the per-beat flags (see fp_special_result_pack_if)
//     flagClear      : zeroes sticky flags (sticky build only)
//     stickyInvalid  : accumulated invalid flag of popped beats
//     stickyOverflow : accumulated overflow flag of popped beats
//     state_dbg      : buffer FSM state (0 EMPTY, 1 ONE, 2 TWO)
//
//   Build option:
//     FP_STICKY_FLAGS_EN : when defined, sticky flag registers are present.
//                          When undefined, both sticky outputs are tied to 0
//                          and flagClear is ignored.
// ---------------------------------------------------------------------------
module fp_special_result_pack #(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 8,
  parameter int SIG_WIDTH = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  fp_special_result_pack_if.slave bus,
  input  logic                  flagClear,
  output logic                  stickyInvalid,
  output logic                  stickyOverflow,
  output logic [1:0]            state_dbg
);

  localparam logic [WIDTH-1:0] QNAN =
    {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(SIG_WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] PINF =
    {1'b0, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
  localparam logic [WIDTH-1:0] NINF =
    {1'b1, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             inv;
    logic             ovf;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   in_ready_q;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  entry_t new_entry;

  logic                 raw_sign;
  logic [EXP_WIDTH-1:0] raw_exp;
  logic                 push;
  logic                 pop;
  logic                 out_valid;

  assign raw_sign = bus.rawResult[WIDTH-1];
  assign raw_exp  = bus.rawResult[WIDTH-2 -: EXP_WIDTH];

  // Result selection. Priority order matters: an operand NaN beats any Inf
  // combination, and +Inf together with -Inf is the invalid Inf-Inf case.
  always_comb begin
    new_entry = '{res: bus.rawResult, inv: 1'b0, ovf: 1'b0};
    if (bus.setResultNaN) begin
      new_entry.res = QNAN;
    end else if (bus.setResultPInf && bus.setResultNInf) begin
      new_entry.res = QNAN;
      new_entry.inv = 1'b1;
    end else if (bus.setResultPInf) begin
      new_entry.res = PINF;
    end else if (bus.setResultNInf) begin
      new_entry.res = NINF;
    end else if (&raw_exp) begin
      // Rounding pushed the exponent to all-ones: force a clean Inf.
      new_entry.res = {raw_sign, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
      new_entry.ovf = 1'b1;
    end
  end

  assign out_valid = (state_q != EMPTY);
  assign push      = bus.inValid & in_ready_q;
  assign pop       = out_valid & bus.outReady;

  // Buffer FSM: head_q is always the entry presented downstream.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = new_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = new_entry;
        end else if (push) begin
          tail_d  = new_entry;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // inReady is low here, so only a pop can happen.
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // inReady comes straight from a flop so that outReady never reaches
  // the upstream ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  assign bus.inReady      = in_ready_q;
  assign bus.outValid     = out_valid;
  assign bus.result       = head_q.res;
  assign bus.flagInvalid  = head_q.inv;
  assign bus.flagOverflow = head_q.ovf;
  assign state_dbg        = state_q;

`ifdef FP_STICKY_FLAGS_EN
  logic sticky_inv_q;
  logic sticky_ovf_q;

  // A clear takes priority over a pop that would set a flag in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || flagClear) begin
      sticky_inv_q <= 1'b0;
      sticky_ovf_q <= 1'b0;
    end else if (pop) begin
      sticky_inv_q <= sticky_inv_q | head_q.inv;
      sticky_ovf_q <= sticky_ovf_q | head_q.ovf;
    end
  end

  assign stickyInvalid  = sticky_inv_q;
  assign stickyOverflow = sticky_ovf_q;
`else
  logic unused_flag_clear;
  assign unused_flag_clear = flagClear;
  assign stickyInvalid     = 1'b0;
  assign stickyOverflow    = 1'b0;
`endif

endmodule
